// File: rtl/boot_reset_sequencer.sv
// Boot-clock bring-up sequencer: power-on wait, PLL enable with lock timeout/retry,
// then staged release of downstream resets once the PLL lock is confirmed.
//   state        | meaning
//   POR_WAIT  0  | power-on wait, PLL off
//   LOCK_WAIT 1  | PLL on, waiting for synchronised lock
//   PLL_OFF   2  | PLL held off between lock retries
//   RELEASE   3  | staged reset release, one bit per STAGE_GAP cycles
//   RUN       4  | all resets released
//   ERROR     5  | retries exhausted, sticky until RESET
module boot_reset_sequencer #(
    parameter int POR_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 256,
    parameter int LOCK_RETRIES = 2,
    parameter int STAGE_GAP    = 8,
    parameter int NUM_STAGES   = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  PLL_LOCK,
    output logic                  PLL_EN,
    output logic [NUM_STAGES-1:0] RST_OUT,
    output logic                  DONE,
    output logic                  ERROR,
    output logic [2:0]            STATE
);

    localparam int CNT_MAX_A = (POR_CYCLES > LOCK_TIMEOUT) ? POR_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STAGE_GAP) ? CNT_MAX_A : STAGE_GAP;
    localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RW        = (LOCK_RETRIES > 0) ? $clog2(LOCK_RETRIES + 1) : 1;

    localparam logic [CW-1:0] POR_LAST     = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(LOCK_RETRIES);

    typedef enum logic [2:0] {
        ST_POR_WAIT  = 3'd0,
        ST_LOCK_WAIT = 3'd1,
        ST_PLL_OFF   = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_ERROR     = 3'd5
    } state_t;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [RW-1:0]         retry_q, retry_d;
    logic                  pll_en_q, pll_en_d;
    logic [NUM_STAGES-1:0] rst_q, rst_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  sync_q, lock_s_q;
    logic [NUM_STAGES-1:0] rst_next;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_POR_WAIT;
            cnt_q    <= '0;
            retry_q  <= '0;
            pll_en_q <= 1'b0;
            rst_q    <= '1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sync_q   <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            pll_en_q <= pll_en_d;
            rst_q    <= rst_d;
            done_q   <= done_d;
            err_q    <= err_d;
            sync_q   <= PLL_LOCK;
            lock_s_q <= sync_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        pll_en_d = pll_en_q;
        rst_d    = rst_q;
        done_d   = done_q;
        err_d    = err_q;
        // Remaining asserted resets always occupy the top bits, so a shift releases the lowest.
        rst_next = rst_q << 1;

        case (state_q)
            ST_POR_WAIT: begin
                pll_en_d = 1'b0;
                if (cnt_q == POR_LAST) begin
                    state_d  = ST_LOCK_WAIT;
                    pll_en_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LOCK_WAIT: begin
                pll_en_d = 1'b1;
                if (lock_s_q) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d    = '0;
                    pll_en_d = 1'b0;
                    if (retry_q < RETRY_MAX) begin
                        state_d = ST_PLL_OFF;
                        retry_d = retry_q + RW'(1);
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PLL_OFF: begin
                pll_en_d = 1'b0;
                if (cnt_q == POR_LAST) begin
                    state_d  = ST_LOCK_WAIT;
                    pll_en_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RELEASE: begin
                if (!lock_s_q) begin
                    state_d  = ST_LOCK_WAIT;
                    cnt_d    = '0;
                    pll_en_d = 1'b1;
                    rst_d    = '1;
                    done_d   = 1'b0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    rst_d = rst_next;
                    if (rst_next == '0) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                        retry_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d  = ST_LOCK_WAIT;
                    cnt_d    = '0;
                    pll_en_d = 1'b1;
                    rst_d    = '1;
                    done_d   = 1'b0;
                end
            end
            ST_ERROR: begin
                err_d    = 1'b1;
                pll_en_d = 1'b0;
                rst_d    = '1;
                done_d   = 1'b0;
            end
            default: begin
                state_d  = ST_POR_WAIT;
                cnt_d    = '0;
                retry_d  = '0;
                pll_en_d = 1'b0;
                rst_d    = '1;
                done_d   = 1'b0;
                err_d    = 1'b0;
            end
        endcase
    end

    assign PLL_EN  = pll_en_q;
    assign RST_OUT = rst_q;
    assign DONE    = done_q;
    assign ERROR   = err_q;
    assign STATE   = state_q;

endmodule

// File: tb/tb_boot_reset_sequencer.sv
// Directed bench for boot_reset_sequencer: expected output tuples are queued per edge
// number and compared by a negedge checker as the DUT reaches each edge.
module tb_boot_reset_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       PLL_LOCK = 1'b0;
    logic       PLL_EN;
    logic [2:0] RST_OUT;
    logic       DONE;
    logic       ERROR;
    logic [2:0] STATE;

    boot_reset_sequencer dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .PLL_LOCK (PLL_LOCK),
        .PLL_EN   (PLL_EN),
        .RST_OUT  (RST_OUT),
        .DONE     (DONE),
        .ERROR    (ERROR),
        .STATE    (STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        int         k;
        string      tag;
        logic [2:0] st;
        logic       pll;
        logic [2:0] rst;
        logic       done;
        logic       err;
        int         retry;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   base = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   started = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void push(int k, string tag, logic [2:0] st, logic pll, logic [2:0] rst,
                                 logic done, logic err, int retry = -1);
        exp_t e;
        e.cyc   = base + k;
        e.k     = k;
        e.tag   = tag;
        e.st    = st;
        e.pll   = pll;
        e.rst   = rst;
        e.done  = done;
        e.err   = err;
        e.retry = retry;
        q.push_back(e);
    endfunction

    initial begin
        exp_t       e;
        logic [2:0] nr;
        forever begin
            @(negedge CLK);
            if (started) begin
                nr = ~RST_OUT;
                n_tests++;
                assert (((nr + 3'd1) & nr) === 3'd0)
                else begin
                    n_fail++;
                    $error("FAIL rst_order cyc %0d: got RST_OUT=%b, want contiguous high bits", cyc, RST_OUT);
                end
            end
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_tests++;
                assert ({STATE, PLL_EN, RST_OUT, DONE, ERROR} === {e.st, e.pll, e.rst, e.done, e.err})
                else begin
                    n_fail++;
                    $error("FAIL %s edge %0d: got st=%0d pll_en=%b rst=%b done=%b err=%b, want st=%0d pll_en=%b rst=%b done=%b err=%b",
                           e.tag, e.k, STATE, PLL_EN, RST_OUT, DONE, ERROR, e.st, e.pll, e.rst, e.done, e.err);
                end
                if (e.retry >= 0) begin
                    n_tests++;
                    assert (int'(dut.retry_q) == e.retry)
                    else begin
                        n_fail++;
                        $error("FAIL %s_retry edge %0d: got %0d, want %0d", e.tag, e.k, dut.retry_q, e.retry);
                    end
                end
            end
        end
    end

    // Call at a negedge (or time 0): the next posedge is the reset edge, numbered 0.
    task automatic apply_reset();
        RESET = 1'b1;
        base  = cyc + 1;
        push(0, "reset", 3'd0, 1'b0, 3'b111, 1'b0, 1'b0, 0);
        @(negedge CLK);
        RESET   = 1'b0;
        started = 1'b1;
    endtask

    task automatic wait_edge(int k);
        while (cyc < base + k) @(negedge CLK);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && q.size() > 0; i++) @(negedge CLK);
        n_tests++;
        assert (q.size() == 0)
        else begin
            n_fail++;
            $error("FAIL drain: got %0d pending checks, want 0", q.size());
        end
    endtask

    task automatic push_s1();
        push(15, "s1_por", 3'd0, 1'b0, 3'b111, 1'b0, 1'b0);
        push(16, "s1_pllen", 3'd1, 1'b1, 3'b111, 1'b0, 1'b0);
        push(17, "s1_rel", 3'd3, 1'b1, 3'b111, 1'b0, 1'b0);
        push(24, "s1_pre0", 3'd3, 1'b1, 3'b111, 1'b0, 1'b0);
        push(25, "s1_b0", 3'd3, 1'b1, 3'b110, 1'b0, 1'b0);
        push(32, "s1_pre1", 3'd3, 1'b1, 3'b110, 1'b0, 1'b0);
        push(33, "s1_b1", 3'd3, 1'b1, 3'b100, 1'b0, 1'b0);
        push(40, "s1_pre2", 3'd3, 1'b1, 3'b100, 1'b0, 1'b0);
        push(41, "s1_done", 3'd4, 1'b1, 3'b000, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Nominal bring-up with lock present throughout
        PLL_LOCK = 1'b1;
        apply_reset();
        push_s1();
        push(60, "s1_run", 3'd4, 1'b1, 3'b000, 1'b1, 1'b0, 0);
        wait_edge(60);
        drain();

        // Lock loss in RUN, then relock
        apply_reset();
        push_s1();
        push(52, "s3_hold", 3'd4, 1'b1, 3'b000, 1'b1, 1'b0);
        push(53, "s3_drop", 3'd1, 1'b1, 3'b111, 1'b0, 1'b0);
        push(62, "s3_wait", 3'd1, 1'b1, 3'b111, 1'b0, 1'b0);
        push(63, "s3_rel", 3'd3, 1'b1, 3'b111, 1'b0, 1'b0);
        push(70, "s3_pre0", 3'd3, 1'b1, 3'b111, 1'b0, 1'b0);
        push(71, "s3_b0", 3'd3, 1'b1, 3'b110, 1'b0, 1'b0);
        push(79, "s3_b1", 3'd3, 1'b1, 3'b100, 1'b0, 1'b0);
        push(86, "s3_pre2", 3'd3, 1'b1, 3'b100, 1'b0, 1'b0);
        push(87, "s3_done", 3'd4, 1'b1, 3'b000, 1'b1, 1'b0);
        wait_edge(50);
        PLL_LOCK = 1'b0;
        wait_edge(60);
        PLL_LOCK = 1'b1;
        wait_edge(90);
        drain();

        // RESET mid-release, then full replay
        apply_reset();
        push(24, "s4_pre0", 3'd3, 1'b1, 3'b111, 1'b0, 1'b0);
        push(25, "s4_b0", 3'd3, 1'b1, 3'b110, 1'b0, 1'b0);
        wait_edge(25);
        apply_reset();
        push_s1();
        push(60, "s4_run", 3'd4, 1'b1, 3'b000, 1'b1, 1'b0, 0);
        wait_edge(60);
        drain();

        // No lock: two retries then ERROR, which ignores a late lock
        PLL_LOCK = 1'b0;
        apply_reset();
        push(16, "s2_pllen", 3'd1, 1'b1, 3'b111, 1'b0, 1'b0);
        push(271, "s2_w1", 3'd1, 1'b1, 3'b111, 1'b0, 1'b0);
        push(272, "s2_to1", 3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 1);
        push(287, "s2_off1", 3'd2, 1'b0, 3'b111, 1'b0, 1'b0);
        push(288, "s2_on1", 3'd1, 1'b1, 3'b111, 1'b0, 1'b0);
        push(543, "s2_w2", 3'd1, 1'b1, 3'b111, 1'b0, 1'b0);
        push(544, "s2_to2", 3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 2);
        push(559, "s2_off2", 3'd2, 1'b0, 3'b111, 1'b0, 1'b0);
        push(560, "s2_on2", 3'd1, 1'b1, 3'b111, 1'b0, 1'b0);
        push(815, "s2_w3", 3'd1, 1'b1, 3'b111, 1'b0, 1'b0);
        push(816, "s2_err", 3'd5, 1'b0, 3'b111, 1'b0, 1'b1);
        push(830, "s2_errhold", 3'd5, 1'b0, 3'b111, 1'b0, 1'b1);
        push(840, "s2_errlock", 3'd5, 1'b0, 3'b111, 1'b0, 1'b1);
        wait_edge(820);
        PLL_LOCK = 1'b1;
        wait_edge(840);
        drain();

        // Lock arriving on the timeout edge of the second window wins
        PLL_LOCK = 1'b0;
        apply_reset();
        push(272, "s5_to1", 3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 1);
        push(288, "s5_on1", 3'd1, 1'b1, 3'b111, 1'b0, 1'b0);
        push(543, "s5_w2", 3'd1, 1'b1, 3'b111, 1'b0, 1'b0);
        push(544, "s5_race", 3'd3, 1'b1, 3'b111, 1'b0, 1'b0, 1);
        push(551, "s5_pre0", 3'd3, 1'b1, 3'b111, 1'b0, 1'b0);
        push(552, "s5_b0", 3'd3, 1'b1, 3'b110, 1'b0, 1'b0);
        push(568, "s5_done", 3'd4, 1'b1, 3'b000, 1'b1, 1'b0, 0);
        // Illegal state recovery
        push(576, "s6_recover", 3'd0, 1'b0, 3'b111, 1'b0, 1'b0, 0);
        push(591, "s6_por", 3'd0, 1'b0, 3'b111, 1'b0, 1'b0);
        push(592, "s6_pllen", 3'd1, 1'b1, 3'b111, 1'b0, 1'b0);
        push(593, "s6_rel", 3'd3, 1'b1, 3'b111, 1'b0, 1'b0);
        wait_edge(541);
        PLL_LOCK = 1'b1;
        wait_edge(575);
        force dut.state_q = 3'd7;
        #1;
        release dut.state_q;
        wait_edge(595);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
